// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - state encoding and opcodes shared by the addsub_arbiter slice
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_rr_arb.sv
// rtl/addsub_rr_arb.sv - one-hot winner select; round-robin under ADDSUB_ARB_RR_EN, else fixed priority
module addsub_rr_arb #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
`ifdef ADDSUB_ARB_RR_EN
    input  logic [PW-1:0]    ptr,
`endif
    output logic [N_REQ-1:0] win
);

`ifdef ADDSUB_ARB_RR_EN
    logic          found;
    logic [PW-1:0] idx;

    // Search begins one past the last winner so the previous winner is considered last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - shares one add/subtract unit among N_REQ requesters; ADDSUB_ARB_RR_EN selects round-robin
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    op,
    input  logic [N_REQ*DW-1:0] a_flat,
    input  logic [N_REQ*DW-1:0] b_flat,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW:0]         result,
    output logic                busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state, next_state;
    logic [N_REQ-1:0] win;
    logic [DW-1:0]    a_sel, b_sel, a_q, b_q;
    logic             op_sel, op_q;

`ifdef ADDSUB_ARB_RR_EN
    logic [PW-1:0] ptr, gnt_idx;

    addsub_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ptr <= PW'(N_REQ - 1);
        else if (state == RESP) ptr <= gnt_idx;
    end
`else
    addsub_rr_arb #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req (req),
        .win (win)
    );
`endif

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                a_sel  = a_flat[i*DW +: DW];
                b_sel  = b_flat[i*DW +: DW];
                op_sel = op[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is registered on the RESP->IDLE edge, so it lands in the cycle whose
    // closing edge is the next arbitration point; dropping req then avoids a regrant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    gnt  <= win;
                    a_q  <= a_sel;
                    b_q  <= b_sel;
                    op_q <= op_sel;
                end
                EXEC: begin
                    // The extra MSB of a DW+1 wide difference is exactly the borrow.
                    case (op_q)
                        OP_SUB:  result <= {1'b0, a_q} - {1'b0, b_q};
                        default: result <= {1'b0, a_q} + {1'b0, b_q};
                    endcase
                end
                RESP: begin
                    done <= gnt;
                    gnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - randomized self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    op  = '0;
    logic [N*DW-1:0] a_flat = '0;
    logic [N*DW-1:0] b_flat = '0;
    logic [N-1:0]    gnt, done;
    logic [DW:0]     result;
    logic            busy;

    int checks_total  = 0;
    int checks_passed = 0;
    int last_win      = N - 1;

    addsub_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .a_flat (a_flat),
        .b_flat (b_flat),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW:0] model_result(input logic o, input int a, input int b);
        int r;
        if (o) r = (a >= b) ? (a - b) : (512 + a - b);
        else   r = a + b;
        return 9'(r);
    endfunction

    function automatic int model_pick(input logic [N-1:0] r);
`ifdef ADDSUB_ARB_RR_EN
        for (int i = 1; i <= N; i++) begin
            if (r[(last_win + i) % N]) return (last_win + i) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    task automatic test_reset;
        checks_total++; if (gnt !== '0) $display("FAIL reset_gnt got %h expected 0", gnt); else checks_passed++;
        checks_total++; if (done !== '0) $display("FAIL reset_done got %h expected 0", done); else checks_passed++;
        checks_total++; if (result !== '0) $display("FAIL reset_result got %h expected 0", result); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else checks_passed++;
    endtask

    task automatic do_op(input int r, input logic o, input int a, input int b);
        logic [DW:0]  exp_res;
        logic [N-1:0] exp_g;
        int           w;
        req = '0;
        req[r] = 1'b1;
        op[r] = o;
        a_flat[r*DW +: DW] = 8'(a);
        b_flat[r*DW +: DW] = 8'(b);
        w = model_pick(req);
        exp_g = onehot(w);
        exp_res = model_result(o, a, b);
        @(posedge clk); #1;
        checks_total++; if (gnt !== exp_g) $display("FAIL op_gnt got %h expected %h", gnt, exp_g); else checks_passed++;
        checks_total++; if (busy !== 1'b1) $display("FAIL op_busy got %b expected 1", busy); else checks_passed++;
        req = '0;
        op = 4'($urandom);
        a_flat = 32'($urandom);
        b_flat = 32'($urandom);
        @(posedge clk); #1;
        checks_total++; if (done !== '0) $display("FAIL op_early_done got %h expected 0", done); else checks_passed++;
        checks_total++; if (result !== exp_res) $display("FAIL op_result got %h expected %h", result, exp_res); else checks_passed++;
        @(posedge clk); #1;
        checks_total++; if (done !== exp_g) $display("FAIL op_done got %h expected %h", done, exp_g); else checks_passed++;
        checks_total++; if (gnt !== '0) $display("FAIL op_gnt_clear got %h expected 0", gnt); else checks_passed++;
        checks_total++; if (result !== exp_res) $display("FAIL op_result_hold got %h expected %h", result, exp_res); else checks_passed++;
        last_win = w;
        @(posedge clk); #1;
        checks_total++; if (done !== '0 || gnt !== '0) $display("FAIL op_idle got done=%h gnt=%h expected 0/0", done, gnt); else checks_passed++;
    endtask

    task automatic test_directed;
        do_op(0, 1'b0, 15, 12);
        do_op(0, 1'b1, 15, 12);
        do_op(0, 1'b1, 12, 15);
        do_op(0, 1'b0, 200, 100);
        do_op(3, 1'b1, 0, 255);
        do_op(1, 1'b0, 255, 255);
    endtask

    task automatic test_random;
        for (int k = 0; k < 16; k++) begin
            do_op(int'($urandom_range(N - 1)), 1'($urandom), int'($urandom_range(255)), int'($urandom_range(255)));
        end
    endtask

    task automatic test_contention;
        logic [DW:0]  exp_res;
        logic [N-1:0] exp_g;
        int           w;
        op = 4'($urandom);
        a_flat = 32'($urandom);
        b_flat = 32'($urandom);
        req = '1;
        for (int n = 0; n < 5; n++) begin
            w = model_pick(req);
            exp_g = onehot(w);
            exp_res = model_result(op[w], int'(a_flat[w*DW +: DW]), int'(b_flat[w*DW +: DW]));
            @(posedge clk); #1;
            checks_total++; if (gnt !== exp_g) $display("FAIL cont_gnt%0d got %h expected %h", n, gnt, exp_g); else checks_passed++;
            @(posedge clk); #1;
            checks_total++; if (result !== exp_res) $display("FAIL cont_result%0d got %h expected %h", n, result, exp_res); else checks_passed++;
            @(posedge clk); #1;
            checks_total++; if (done !== exp_g) $display("FAIL cont_done%0d got %h expected %h", n, done, exp_g); else checks_passed++;
            last_win = w;
            if (n == 4) req = '0;
        end
        @(posedge clk); #1;
        checks_total++; if (gnt !== '0 || busy !== 1'b0) $display("FAIL cont_release got gnt=%h busy=%b expected 0/0", gnt, busy); else checks_passed++;
    endtask

    task automatic test_reset_mid;
        req = 4'b0010;
        op[1] = 1'b0;
        a_flat[1*DW +: DW] = 8'd77;
        b_flat[1*DW +: DW] = 8'd99;
        @(posedge clk); #1;
        checks_total++; if (gnt !== 4'b0010) $display("FAIL mid_gnt got %h expected 2", gnt); else checks_passed++;
        req = 4'b0100;
        #1 rst = 1'b1;
        #1;
        checks_total++; if (gnt !== '0) $display("FAIL mid_rst_gnt got %h expected 0", gnt); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b expected 0", busy); else checks_passed++;
        checks_total++; if (result !== '0) $display("FAIL mid_rst_result got %h expected 0", result); else checks_passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks_total++; if (done !== '0) $display("FAIL mid_rst_done got %h expected 0", done); else checks_passed++;
        end
        rst = 1'b0;
        last_win = N - 1;
        do_op(2, 1'b1, 40, 41);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_random();
        test_contention();
        test_reset_mid();
        test_contention();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
